// File: rtl/can_pkg.sv
// Shared types and defaults for the CAN frame-phase sequencer.
// phase_t encodings are visible on the PHASE output and must not be renumbered.
package can_pkg;

    typedef enum logic [2:0] {
        INTEGRATE = 3'd0,
        IDLE      = 3'd1,
        FRAME     = 3'd2,
        ERR_FLAG  = 3'd3,
        OVL_FLAG  = 3'd4,
        INTERM    = 3'd5
    } phase_t;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    localparam int IDLE_BITS_DEF    = 11;
    localparam int INTERM_BITS_DEF  = 3;
    localparam int MAX_OVLD_DEF     = 2;
    localparam int FLAG_TIMEOUT_DEF = 31;
    localparam int BIT_CNT_W        = 8;

endpackage

// File: rtl/can_bit_counter.sv
// Saturating bit/cycle counter shared by every sequencer phase.
// Clear has priority over enable; the count holds at its maximum instead of wrapping.
module can_bit_counter
    import can_pkg::*;
(
    input  logic                 SP,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [BIT_CNT_W-1:0] count
);

    localparam logic [BIT_CNT_W-1:0] CNT_MAX = '1;

    logic [BIT_CNT_W-1:0] count_q;
    logic [BIT_CNT_W-1:0] count_d;

    // NOTE: assign the hold value first so every path drives count_d and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/can_frame_sequencer.sv
// Bit-level bus-phase controller for the CAN decoder, clocked once per sample point.
// Owns the only start pulses for the overload and error frame makers.
module can_frame_sequencer
    import can_pkg::*;
#(
    parameter int IDLE_BITS    = IDLE_BITS_DEF,
    parameter int INTERM_BITS  = INTERM_BITS_DEF,
    parameter int MAX_OVLD     = MAX_OVLD_DEF,
    parameter int FLAG_TIMEOUT = FLAG_TIMEOUT_DEF
) (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       EOF_DONE,
    input  logic       ERROR,
    input  logic       OVLD_REQ,
    input  logic       F_ITMSS,
    output logic       F_OVRLD,
    output logic       F_ERRFR,
    output logic       DEC_EN,
    output logic       BUS_IDLE,
    output logic       SOF,
    output logic [2:0] PHASE,
    output logic [1:0] OVLD_CNT
);

    // Phase changes fire on the edge where the counter would reach its limit.
    localparam logic [BIT_CNT_W-1:0] IDLE_LAST   = BIT_CNT_W'(IDLE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] INTERM_LAST = BIT_CNT_W'(INTERM_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] FLAG_LAST   = BIT_CNT_W'(FLAG_TIMEOUT - 1);
    localparam logic [1:0]           OVLD_MAX    = 2'(MAX_OVLD);

    phase_t               phase_q, phase_d;
    logic [1:0]           ovld_cnt_q, ovld_cnt_d;
    logic                 f_ovrld_q, f_ovrld_d;
    logic                 f_errfr_q, f_errfr_d;
    logic                 dec_en_q, dec_en_d;
    logic                 bus_idle_q, bus_idle_d;
    logic                 sof_q, sof_d;
    logic                 cnt_clr, cnt_en;
    logic [BIT_CNT_W-1:0] bit_cnt;

    can_bit_counter u_bit_counter (
        .SP    (SP),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bit_cnt)
    );

    always_comb begin
        phase_d    = phase_q;
        ovld_cnt_d = ovld_cnt_q;
        case (phase_q)
            INTEGRATE: begin
                if (RX == CAN_RECESSIVE && bit_cnt == IDLE_LAST) phase_d = IDLE;
            end
            IDLE: begin
                if (RX == CAN_DOMINANT) phase_d = FRAME;
            end
            FRAME: begin
                if (ERROR) begin
                    phase_d = ERR_FLAG;
                end else if (EOF_DONE) begin
                    phase_d    = INTERM;
                    ovld_cnt_d = '0;
                end
            end
            INTERM: begin
                if (bit_cnt == '0 && OVLD_REQ && ovld_cnt_q < OVLD_MAX) begin
                    phase_d    = OVL_FLAG;
                    ovld_cnt_d = ovld_cnt_q + 2'd1;
                end else if (RX == CAN_DOMINANT) begin
                    phase_d = (bit_cnt < INTERM_LAST) ? OVL_FLAG : FRAME;
                end else if (bit_cnt == INTERM_LAST) begin
                    phase_d = IDLE;
                end
            end
            OVL_FLAG, ERR_FLAG: begin
                if (phase_q == OVL_FLAG && ERROR) begin
                    phase_d = ERR_FLAG;
                end else if (!F_ITMSS) begin
                    phase_d = INTERM;
                end else if (bit_cnt == FLAG_LAST) begin
                    phase_d = INTEGRATE;
                end
            end
            default: phase_d = INTEGRATE;
        endcase

        // Every phase entry restarts the counter; integration also restarts on a dominant bit.
        cnt_clr = (phase_d != phase_q) || (phase_q == IDLE) || (phase_q == FRAME) ||
                  (phase_q == INTEGRATE && RX == CAN_DOMINANT);
        cnt_en  = 1'b1;

        f_ovrld_d  = !(phase_d == OVL_FLAG && phase_q != OVL_FLAG);
        f_errfr_d  = !(phase_d == ERR_FLAG && phase_q != ERR_FLAG);
        sof_d      = (phase_d == FRAME && phase_q != FRAME);
        dec_en_d   = (phase_d == FRAME);
        bus_idle_d = (phase_d == IDLE);
    end

    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            phase_q    <= INTEGRATE;
            ovld_cnt_q <= '0;
            f_ovrld_q  <= 1'b1;
            f_errfr_q  <= 1'b1;
            dec_en_q   <= 1'b0;
            bus_idle_q <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            ovld_cnt_q <= ovld_cnt_d;
            f_ovrld_q  <= f_ovrld_d;
            f_errfr_q  <= f_errfr_d;
            dec_en_q   <= dec_en_d;
            bus_idle_q <= bus_idle_d;
            sof_q      <= sof_d;
        end
    end

    assign PHASE    = phase_q;
    assign OVLD_CNT = ovld_cnt_q;
    assign F_OVRLD  = f_ovrld_q;
    assign F_ERRFR  = f_errfr_q;
    assign DEC_EN   = dec_en_q;
    assign BUS_IDLE = bus_idle_q;
    assign SOF      = sof_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed self-checking bench for can_frame_sequencer.
// Inputs change 1 time unit after each SP edge; outputs are sampled at the same point.
module tb_can_frame_sequencer;
    import can_pkg::*;

    logic       SP = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic       EOF_DONE = 1'b0;
    logic       ERROR = 1'b0;
    logic       OVLD_REQ = 1'b0;
    logic       F_ITMSS = 1'b1;
    logic       F_OVRLD, F_ERRFR, DEC_EN, BUS_IDLE, SOF;
    logic [2:0] PHASE;
    logic [1:0] OVLD_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    can_frame_sequencer dut (
        .SP       (SP),
        .reset    (reset),
        .RX       (RX),
        .EOF_DONE (EOF_DONE),
        .ERROR    (ERROR),
        .OVLD_REQ (OVLD_REQ),
        .F_ITMSS  (F_ITMSS),
        .F_OVRLD  (F_OVRLD),
        .F_ERRFR  (F_ERRFR),
        .DEC_EN   (DEC_EN),
        .BUS_IDLE (BUS_IDLE),
        .SOF      (SOF),
        .PHASE    (PHASE),
        .OVLD_CNT (OVLD_CNT)
    );

    always #5 SP = ~SP;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input phase_t ph, input logic ovr,
                              input logic err, input logic dec, input logic idle,
                              input logic sof, input logic [1:0] oc);
        check({tag, ".PHASE"},    8'(PHASE),    8'(ph));
        check({tag, ".F_OVRLD"},  8'(F_OVRLD),  8'(ovr));
        check({tag, ".F_ERRFR"},  8'(F_ERRFR),  8'(err));
        check({tag, ".DEC_EN"},   8'(DEC_EN),   8'(dec));
        check({tag, ".BUS_IDLE"}, 8'(BUS_IDLE), 8'(idle));
        check({tag, ".SOF"},      8'(SOF),      8'(sof));
        check({tag, ".OVLD_CNT"}, 8'(OVLD_CNT), 8'(oc));
    endtask

    // Apply one bus bit and wait until just after the SP edge that samples it.
    task automatic bit_step(input logic rx);
        RX = rx;
        @(posedge SP);
        #1;
    endtask

    initial begin
        // Test 1: reset, integration run broken by a dominant bit, then a full run.
        #2 reset = 1'b0;
        #1 expect_out("reset", INTEGRATE, 1, 1, 0, 0, 0, 2'd0);
        @(posedge SP); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit_step(1'b1);
            check($sformatf("t1_run1_%0d.PHASE", i), 8'(PHASE), 8'(INTEGRATE));
        end
        bit_step(1'b0);
        expect_out("t1_dominant", INTEGRATE, 1, 1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 10; i++) bit_step(1'b1);
        expect_out("t1_bit10", INTEGRATE, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        expect_out("t1_bit11", IDLE, 1, 1, 0, 1, 0, 2'd0);

        // Test 2: SOF from idle, EOF, three recessive intermission bits back to idle.
        bit_step(1'b0);
        expect_out("t2_sof", FRAME, 1, 1, 1, 0, 1, 2'd0);
        bit_step(1'b1);
        expect_out("t2_frame", FRAME, 1, 1, 1, 0, 0, 2'd0);
        EOF_DONE = 1'b1;
        bit_step(1'b1);
        EOF_DONE = 1'b0;
        expect_out("t2_eof", INTERM, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        bit_step(1'b1);
        expect_out("t2_im2", INTERM, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        expect_out("t2_idle", IDLE, 1, 1, 0, 1, 0, 2'd0);

        // Test 3: reactive overload on a dominant second intermission bit.
        bit_step(1'b0);
        EOF_DONE = 1'b1;
        bit_step(1'b1);
        EOF_DONE = 1'b0;
        bit_step(1'b1);
        expect_out("t3_im0", INTERM, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b0);
        expect_out("t3_ovl", OVL_FLAG, 0, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        expect_out("t3_flag", OVL_FLAG, 1, 1, 0, 0, 0, 2'd0);
        F_ITMSS = 1'b0;
        bit_step(1'b1);
        F_ITMSS = 1'b1;
        expect_out("t3_itmss", INTERM, 1, 1, 0, 0, 0, 2'd0);

        // Test 4: requested overloads limited to two, third intermission ends idle.
        bit_step(1'b1);
        bit_step(1'b1);
        bit_step(1'b1);
        check("t4_idle.PHASE", 8'(PHASE), 8'(IDLE));
        bit_step(1'b0);
        OVLD_REQ = 1'b1;
        EOF_DONE = 1'b1;
        bit_step(1'b1);
        EOF_DONE = 1'b0;
        expect_out("t4_eof", INTERM, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        expect_out("t4_req1", OVL_FLAG, 0, 1, 0, 0, 0, 2'd1);
        F_ITMSS = 1'b0;
        bit_step(1'b1);
        F_ITMSS = 1'b1;
        check("t4_im2.PHASE", 8'(PHASE), 8'(INTERM));
        bit_step(1'b1);
        expect_out("t4_req2", OVL_FLAG, 0, 1, 0, 0, 0, 2'd2);
        F_ITMSS = 1'b0;
        bit_step(1'b1);
        F_ITMSS = 1'b1;
        check("t4_im3.PHASE", 8'(PHASE), 8'(INTERM));
        bit_step(1'b1);
        expect_out("t4_ignored", INTERM, 1, 1, 0, 0, 0, 2'd2);
        bit_step(1'b1);
        bit_step(1'b1);
        expect_out("t4_idle", IDLE, 1, 1, 0, 1, 0, 2'd2);
        OVLD_REQ = 1'b0;

        // Test 5: ERROR beats EOF_DONE, then the flag phase times out.
        bit_step(1'b0);
        ERROR = 1'b1;
        EOF_DONE = 1'b1;
        bit_step(1'b1);
        ERROR = 1'b0;
        EOF_DONE = 1'b0;
        expect_out("t5_err", ERR_FLAG, 1, 0, 0, 0, 0, 2'd2);
        ERROR = 1'b1;
        bit_step(1'b1);
        ERROR = 1'b0;
        expect_out("t5_err_ignored", ERR_FLAG, 1, 1, 0, 0, 0, 2'd2);
        for (int i = 2; i < 31; i++) bit_step(1'b1);
        check("t5_cycle30.PHASE", 8'(PHASE), 8'(ERR_FLAG));
        bit_step(1'b1);
        expect_out("t5_timeout", INTEGRATE, 1, 1, 0, 0, 0, 2'd2);

        // Test 6: asynchronous reset in the middle of an overload flag.
        for (int i = 0; i < 11; i++) bit_step(1'b1);
        check("t6_idle.PHASE", 8'(PHASE), 8'(IDLE));
        bit_step(1'b0);
        EOF_DONE = 1'b1;
        bit_step(1'b1);
        EOF_DONE = 1'b0;
        bit_step(1'b0);
        expect_out("t6_ovl", OVL_FLAG, 0, 1, 0, 0, 0, 2'd0);
        #2 reset = 1'b0;
        #1 expect_out("t6_reset", INTEGRATE, 1, 1, 0, 0, 0, 2'd0);
        @(posedge SP); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) bit_step(1'b1);
        expect_out("t6_bit10", INTEGRATE, 1, 1, 0, 0, 0, 2'd0);
        bit_step(1'b1);
        expect_out("t6_bit11", IDLE, 1, 1, 0, 1, 0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
